execute: RTL and testbench

//  EX stage of the 5-stage RV32I pipeline; consumes the ID/EX register outputs of the decode stage.

---
 rtl/execute_pkg.sv | 62 ++++++
 rtl/execute_alu.sv | 44 ++++
 rtl/execute.sv | 134 +++++++++++++
 tb/tb_execute.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/execute_pkg.sv
// Shared EX-stage encodings: ALU opcode classes, ALU functions, forward selects, control payload.
package execute_pkg;

   localparam int unsigned ALUOP_W = 2;
   localparam int unsigned FWD_W   = 2;

   // aluOp classes driven by decode
   localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 2'b00;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_FUNC = 2'b10;
   localparam logic [ALUOP_W-1:0] ALUOP_ADD2 = 2'b11;

   // Operand source selects; EX/MEM beats MEM/WB because it holds the newer value
   localparam logic [FWD_W-1:0] FWD_REG   = 2'b00;
   localparam logic [FWD_W-1:0] FWD_WB    = 2'b01;
   localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b10;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_fn_e;

   // Control bits carried from ID/EX into EX/MEM
   typedef struct packed {
      logic mem_to_reg;
      logic reg_write;
      logic mem_read;
      logic mem_write;
   } ex_mem_ctrl_t;

   // ALU control decode: aluOp class plus funct3/funct7[5] for R-type
   function automatic alu_fn_e alu_ctrl(input logic [ALUOP_W-1:0] alu_op,
                                        input logic [2:0]         funct3,
                                        input logic               funct7_b5);
      alu_fn_e fn;
      fn = ALU_ADD;
      if (alu_op == ALUOP_SUB) begin
         fn = ALU_SUB;
      end else if (alu_op == ALUOP_FUNC) begin
         case (funct3)
            3'b000:  fn = funct7_b5 ? ALU_SUB : ALU_ADD;
            3'b001:  fn = ALU_SLL;
            3'b010:  fn = ALU_SLT;
            3'b011:  fn = ALU_SLTU;
            3'b100:  fn = ALU_XOR;
            3'b101:  fn = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  fn = ALU_OR;
            default: fn = ALU_AND;
         endcase
      end
      return fn;
   endfunction

endpackage

// File: rtl/execute_alu.sv
// Combinational ALU: control decode, operation and zero flag.
module execute_alu
   import execute_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [ALUOP_W-1:0] alu_op,
   input  logic [2:0]         funct3,
   input  logic               funct7_b5,
   input  logic [DATA_W-1:0]  op_a,
   input  logic [DATA_W-1:0]  op_b,
   output logic [DATA_W-1:0]  result_c,
   output logic               zero_c
);

   localparam int unsigned SHAMT_W = $clog2(DATA_W);

   alu_fn_e             fn;
   logic [SHAMT_W-1:0]  shamt;

   assign fn    = alu_ctrl(alu_op, funct3, funct7_b5);
   assign shamt = op_b[SHAMT_W-1:0];

   // Operation select; add/sub wrap, comparisons zero-extend to 0/1
   always_comb begin
      result_c = '0;
      case (fn)
         ALU_ADD:  result_c = op_a + op_b;
         ALU_SUB:  result_c = op_a - op_b;
         ALU_SLL:  result_c = op_a << shamt;
         ALU_SLT:  result_c = DATA_W'($signed(op_a) < $signed(op_b));
         ALU_SLTU: result_c = DATA_W'(op_a < op_b);
         ALU_XOR:  result_c = op_a ^ op_b;
         ALU_SRL:  result_c = op_a >> shamt;
         ALU_SRA:  result_c = DATA_W'($signed(op_a) >>> shamt);
         ALU_OR:   result_c = op_a | op_b;
         ALU_AND:  result_c = op_a & op_b;
         default:  result_c = '0;
      endcase
   end

   assign zero_c = (result_c == '0);

endmodule

// File: rtl/execute.sv
// EX stage: operand forwarding, ALU, and the EX/MEM pipeline register.
module execute
   import execute_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned FWD_EN = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               mem_to_reg_in,
   input  logic               reg_write_in,
   input  logic               mem_read_in,
   input  logic               mem_write_in,
   input  logic               beq_instruction_in,
   input  logic               aluSrc_in,
   input  logic [ALUOP_W-1:0] aluOp_in,
   input  logic [REG_W-1:0]   rs1_in,
   input  logic [REG_W-1:0]   rs2_in,
   input  logic [REG_W-1:0]   rd_in,
   input  logic [DATA_W-1:0]  imediato_in,
   input  logic [DATA_W-1:0]  reg_a_in,
   input  logic [DATA_W-1:0]  reg_b_in,
   input  logic [6:0]         funct7_in,
   input  logic [2:0]         funct3_in,
   input  logic               mem_wb_reg_write,
   input  logic [REG_W-1:0]   mem_wb_rd,
   input  logic [DATA_W-1:0]  wb_data,
   output logic               mem_to_reg_out,
   output logic               reg_write_out,
   output logic               mem_read_out,
   output logic               mem_write_out,
   output logic [DATA_W-1:0]  alu_result_out,
   output logic [DATA_W-1:0]  store_data_out,
   output logic [REG_W-1:0]   rd_out,
   output logic               zero_out,
   output logic [FWD_W-1:0]   fwd_a_dbg,
   output logic [FWD_W-1:0]   fwd_b_dbg
);

   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] fwd_b_val;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] alu_result_c;
   logic              alu_zero_c;
   logic              bubble;
   ex_mem_ctrl_t      ctrl;

   // Only the sub/sra selector bit of funct7 matters to RV32I
   logic unused_funct7;
   assign unused_funct7 = ^{funct7_in[6], funct7_in[4:0]};

   assign ctrl = '{mem_to_reg: mem_to_reg_in, reg_write: reg_write_in,
                   mem_read: mem_read_in, mem_write: mem_write_in};

   // beq keeps its datapath alive so the zero flag is meaningful; a true bubble does not
   assign bubble = ~(|ctrl) & ~beq_instruction_in;

   // Forward selects: newest producer wins, x0 is never forwarded
   always_comb begin
      fwd_a_dbg = FWD_REG;
      fwd_b_dbg = FWD_REG;
      if (FWD_EN != 0) begin
         if (reg_write_out && (rd_out != '0) && (rd_out == rs1_in))
            fwd_a_dbg = FWD_EXMEM;
         else if (mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == rs1_in))
            fwd_a_dbg = FWD_WB;
         if (reg_write_out && (rd_out != '0) && (rd_out == rs2_in))
            fwd_b_dbg = FWD_EXMEM;
         else if (mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == rs2_in))
            fwd_b_dbg = FWD_WB;
      end
   end

   // Operand muxes; store data is taken before the immediate select
   always_comb begin
      op_a = reg_a_in;
      case (fwd_a_dbg)
         FWD_EXMEM: op_a = alu_result_out;
         FWD_WB:    op_a = wb_data;
         default:   op_a = reg_a_in;
      endcase
      fwd_b_val = reg_b_in;
      case (fwd_b_dbg)
         FWD_EXMEM: fwd_b_val = alu_result_out;
         FWD_WB:    fwd_b_val = wb_data;
         default:   fwd_b_val = reg_b_in;
      endcase
      op_b = aluSrc_in ? imediato_in : fwd_b_val;
   end

   execute_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .alu_op    (aluOp_in),
      .funct3    (funct3_in),
      .funct7_b5 (funct7_in[5]),
      .op_a      (op_a),
      .op_b      (op_b),
      .result_c  (alu_result_c),
      .zero_c    (alu_zero_c)
   );

   // EX/MEM register; bubbles carry cleared data so they can never alias a forward
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_to_reg_out <= 1'b0;
         reg_write_out  <= 1'b0;
         mem_read_out   <= 1'b0;
         mem_write_out  <= 1'b0;
         alu_result_out <= '0;
         store_data_out <= '0;
         rd_out         <= '0;
         zero_out       <= 1'b0;
      end else begin
         mem_to_reg_out <= ctrl.mem_to_reg;
         reg_write_out  <= ctrl.reg_write;
         mem_read_out   <= ctrl.mem_read;
         mem_write_out  <= ctrl.mem_write;
         if (bubble) begin
            alu_result_out <= '0;
            store_data_out <= '0;
            rd_out         <= '0;
            zero_out       <= 1'b1;
         end else begin
            alu_result_out <= alu_result_c;
            store_data_out <= fwd_b_val;
            rd_out         <= rd_in;
            zero_out       <= alu_zero_c;
         end
      end
   end

endmodule

// File: tb/tb_execute.sv
// Directed bench for the EX stage with hand-computed expectations.
module tb_execute;

   logic        clock;
   logic        reset;
   logic        mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in;
   logic        beq_instruction_in, aluSrc_in;
   logic [1:0]  aluOp_in;
   logic [4:0]  rs1_in, rs2_in, rd_in;
   logic [31:0] imediato_in, reg_a_in, reg_b_in;
   logic [6:0]  funct7_in;
   logic [2:0]  funct3_in;
   logic        mem_wb_reg_write;
   logic [4:0]  mem_wb_rd;
   logic [31:0] wb_data;
   logic        mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out;
   logic [31:0] alu_result_out, store_data_out;
   logic [4:0]  rd_out;
   logic        zero_out;
   logic [1:0]  fwd_a_dbg, fwd_b_dbg;

   int checks = 0;
   int errors = 0;

   execute dut (
      .clock              (clock),
      .reset              (reset),
      .mem_to_reg_in      (mem_to_reg_in),
      .reg_write_in       (reg_write_in),
      .mem_read_in        (mem_read_in),
      .mem_write_in       (mem_write_in),
      .beq_instruction_in (beq_instruction_in),
      .aluSrc_in          (aluSrc_in),
      .aluOp_in           (aluOp_in),
      .rs1_in             (rs1_in),
      .rs2_in             (rs2_in),
      .rd_in              (rd_in),
      .imediato_in        (imediato_in),
      .reg_a_in           (reg_a_in),
      .reg_b_in           (reg_b_in),
      .funct7_in          (funct7_in),
      .funct3_in          (funct3_in),
      .mem_wb_reg_write   (mem_wb_reg_write),
      .mem_wb_rd          (mem_wb_rd),
      .wb_data            (wb_data),
      .mem_to_reg_out     (mem_to_reg_out),
      .reg_write_out      (reg_write_out),
      .mem_read_out       (mem_read_out),
      .mem_write_out      (mem_write_out),
      .alu_result_out     (alu_result_out),
      .store_data_out     (store_data_out),
      .rd_out             (rd_out),
      .zero_out           (zero_out),
      .fwd_a_dbg          (fwd_a_dbg),
      .fwd_b_dbg          (fwd_b_dbg)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle past it
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_ctrl(input logic rw, input logic mr, input logic mw, input logic mtr,
                           input logic alusrc, input logic [1:0] aluop);
      reg_write_in  = rw;
      mem_read_in   = mr;
      mem_write_in  = mw;
      mem_to_reg_in = mtr;
      aluSrc_in     = alusrc;
      aluOp_in      = aluop;
      beq_instruction_in = 1'b0;
   endtask

   task automatic set_ops(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
      rs1_in = rs1; rs2_in = rs2; rd_in = rd;
      reg_a_in = a; reg_b_in = b; imediato_in = imm;
   endtask

   task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
      mem_wb_reg_write = we; mem_wb_rd = rd; wb_data = data;
   endtask

   // R-type ALU vectors: funct3, funct7, a, b, expected
   logic [2:0]  v_f3  [10] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b101,
                               3'b110, 3'b111, 3'b010, 3'b010, 3'b011};
   logic [6:0]  v_f7  [10] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h20,
                               7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
   logic [31:0] v_a   [10] = '{32'hFFFF_FFFF, 32'h1, 32'hF0F0, 32'h8000_0000, 32'h8000_0000,
                               32'hF0, 32'hF0, 32'hFFFF_FFFF, 32'h1, 32'h1};
   logic [31:0] v_b   [10] = '{32'h2, 32'd33, 32'hFF00, 32'h4, 32'h4,
                               32'h0F, 32'h3C, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   logic [31:0] v_exp [10] = '{32'h1, 32'h2, 32'h0FF0, 32'h0800_0000, 32'hF800_0000,
                               32'hFF, 32'h30, 32'h1, 32'h0, 32'h1};
   string       v_tag [10] = '{"add_wrap", "sll_shamt5", "xor", "srl", "sra",
                               "or", "and", "slt_neg", "slt", "sltu"};

   initial begin
      reset = 1'b1;
      set_ctrl(0, 0, 0, 0, 0, 2'b00);
      set_ops(0, 0, 0, 0, 0, 0);
      funct3_in = 3'b000; funct7_in = 7'h00;
      set_wb(0, 0, 0);
      #12;
      check("reset_alu", alu_result_out, 32'h0);
      check("reset_rd", 32'(rd_out), 32'h0);
      check("reset_ctrl", 32'({mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out, zero_out}), 32'h0);
      @(negedge clock);
      reset = 1'b0;

      // R add x6 = x1(5) + x2(7)
      set_ctrl(1, 0, 0, 0, 0, 2'b10);
      set_ops(1, 2, 6, 32'd5, 32'd7, 32'h0);
      #1;
      check("add_fwd_a", 32'(fwd_a_dbg), 32'h0);
      check("add_fwd_b", 32'(fwd_b_dbg), 32'h0);
      tick();
      check("add_result", alu_result_out, 32'd12);
      check("add_rd", 32'(rd_out), 32'd6);
      check("add_zero", 32'(zero_out), 32'h0);
      check("add_rw", 32'(reg_write_out), 32'h1);

      // add x3 = 4 + 5, then sub x4,x3,x3 with stale register reads
      set_ops(1, 2, 3, 32'd4, 32'd5, 32'h0);
      tick();
      check("x3_result", alu_result_out, 32'd9);
      funct7_in = 7'h20;
      set_ops(3, 3, 4, 32'h0, 32'h0, 32'h0);
      #1;
      check("sub_fwd_a", 32'(fwd_a_dbg), 32'h2);
      check("sub_fwd_b", 32'(fwd_b_dbg), 32'h2);
      tick();
      check("sub_result", alu_result_out, 32'h0);
      check("sub_zero", 32'(zero_out), 32'h1);
      funct7_in = 7'h00;

      // x5 = 1 in EX/MEM, MEM/WB also has x5 = 2: EX/MEM wins
      set_ctrl(1, 0, 0, 0, 1, 2'b00);
      set_ops(0, 0, 5, 32'h0, 32'h0, 32'h1);
      tick();
      check("x5_result", alu_result_out, 32'h1);
      set_wb(1, 5, 32'h2);
      set_ops(5, 0, 7, 32'h77, 32'h0, 32'h0);
      #1;
      check("prio_fwd_a", 32'(fwd_a_dbg), 32'h2);
      tick();
      check("prio_operand", alu_result_out, 32'h1);

      // MEM/WB writing x0 is never forwarded
      set_wb(1, 0, 32'hFFFF);
      set_ops(0, 0, 0, 32'h33, 32'h0, 32'h0);
      #1;
      check("wb_x0_fwd_a", 32'(fwd_a_dbg), 32'h0);
      tick();
      check("wb_x0_operand", alu_result_out, 32'h33);

      // EX/MEM writing x0 is never forwarded either
      set_wb(0, 0, 32'h0);
      set_ops(0, 0, 8, 32'h10, 32'h0, 32'h0);
      #1;
      check("exm_x0_fwd_a", 32'(fwd_a_dbg), 32'h0);
      tick();
      check("exm_x0_operand", alu_result_out, 32'h10);

      // Store: base 0x100 + imm -4, data 0xAB forwarded from MEM/WB
      set_ctrl(0, 0, 1, 0, 1, 2'b00);
      set_ops(9, 10, 0, 32'h100, 32'h55, 32'hFFFF_FFFC);
      set_wb(1, 10, 32'hAB);
      #1;
      check("st_fwd_a", 32'(fwd_a_dbg), 32'h0);
      check("st_fwd_b", 32'(fwd_b_dbg), 32'h1);
      tick();
      check("st_addr", alu_result_out, 32'hFC);
      check("st_data", store_data_out, 32'hAB);
      check("st_mw", 32'(mem_write_out), 32'h1);
      check("st_rw", 32'(reg_write_out), 32'h0);
      set_wb(0, 0, 32'h0);

      // R-type function table
      set_ctrl(1, 0, 0, 0, 0, 2'b10);
      for (int i = 0; i < 10; i++) begin
         funct3_in = v_f3[i];
         funct7_in = v_f7[i];
         set_ops(11, 12, 13, v_a[i], v_b[i], 32'h0);
         tick();
         check(v_tag[i], alu_result_out, v_exp[i]);
      end
      funct7_in = 7'h00;

      // aluOp 01 is sub and 11 is add regardless of funct3
      funct3_in = 3'b111;
      set_ctrl(1, 0, 0, 0, 0, 2'b01);
      set_ops(11, 12, 13, 32'd3, 32'd5, 32'h0);
      tick();
      check("aluop_sub", alu_result_out, 32'hFFFF_FFFE);
      set_ctrl(1, 0, 0, 0, 0, 2'b11);
      tick();
      check("aluop_add", alu_result_out, 32'd8);

      // Bubble
      set_ctrl(0, 0, 0, 0, 0, 2'b00);
      tick();
      check("bubble_rw", 32'(reg_write_out), 32'h0);
      check("bubble_mw", 32'(mem_write_out), 32'h0);
      check("bubble_mr", 32'(mem_read_out), 32'h0);

      // Reset mid-cycle clears outputs before the next edge
      funct3_in = 3'b000;
      set_ctrl(1, 1, 0, 1, 0, 2'b10);
      set_ops(1, 2, 6, 32'd5, 32'd7, 32'h0);
      tick();
      check("pre_rst_result", alu_result_out, 32'd12);
      #2;
      reset = 1'b1;
      #1;
      check("rst_async_alu", alu_result_out, 32'h0);
      check("rst_async_rd", 32'(rd_out), 32'h0);
      check("rst_async_ctrl", 32'({mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out, zero_out}), 32'h0);
      tick();
      check("rst_hold_alu", alu_result_out, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
